// File: rtl/pilha_parametrizada.sv
`default_nettype none
// ============================================================================
//  Module   : pilha_parametrizada
//  Purpose  : Parametrised LIFO operand stack. Top two entries are exposed
//             combinationally for the ALU. Supports push, pop, replace-two,
//             swap and dup, with full/empty flags and error reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module pilha_parametrizada #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] D,
  input  logic [2:0]       Op,
  output logic [WIDTH-1:0] TDP,
  output logic [WIDTH-1:0] PDP,
  output logic [CW-1:0]    Count,
  output logic             Empty,
  output logic             Full,
  output logic             Err,
  output logic             ErrSticky
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_PUSH  = 3'b001,
    OP_POP   = 3'b010,
    OP_REPL2 = 3'b011,
    OP_SWAP  = 3'b100,
    OP_DUP   = 3'b101
  } op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;

  // Occupancy as a plain integer so index comparisons never wrap in CW bits
  int               w_cnt;
  logic [WIDTH-1:0] w_tdp, w_pdp;
  logic             w_has1, w_has2, w_room, w_reject;

  assign w_cnt  = int'(count_q);
  assign w_has1 = (w_cnt >= 1);
  assign w_has2 = (w_cnt >= 2);
  assign w_room = (w_cnt < DEPTH);

  // Top and next-below-top selection; absent entries read as zero
  always_comb begin
    w_tdp = '0;
    w_pdp = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_cnt == i + 1) w_tdp = mem_q[i];
      if (w_cnt == i + 2) w_pdp = mem_q[i];
    end
  end

  // Next-state computation: one op per cycle, rejected ops leave state intact
  always_comb begin
    mem_d    = mem_q;
    count_d  = count_q;
    w_reject = 1'b0;
    case (Op)
      OP_PUSH: begin
        if (w_room) begin
          for (int i = 0; i < DEPTH; i++)
            if (w_cnt == i) mem_d[i] = D;
          count_d = count_q + CW'(1);
        end else begin
          w_reject = 1'b1;
        end
      end
      OP_POP: begin
        if (w_has1) begin
          // Clear the vacated slot so stale data never resurfaces
          for (int i = 0; i < DEPTH; i++)
            if (w_cnt == i + 1) mem_d[i] = '0;
          count_d = count_q - CW'(1);
        end else begin
          w_reject = 1'b1;
        end
      end
      OP_REPL2: begin
        if (w_has2) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (w_cnt == i + 2) mem_d[i] = D;
            if (w_cnt == i + 1) mem_d[i] = '0;
          end
          count_d = count_q - CW'(1);
        end else begin
          w_reject = 1'b1;
        end
      end
      OP_SWAP: begin
        if (w_has2) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (w_cnt == i + 1) mem_d[i] = w_pdp;
            if (w_cnt == i + 2) mem_d[i] = w_tdp;
          end
        end else begin
          w_reject = 1'b1;
        end
      end
      OP_DUP: begin
        if (w_has1 && w_room) begin
          for (int i = 0; i < DEPTH; i++)
            if (w_cnt == i) mem_d[i] = w_tdp;
          count_d = count_q + CW'(1);
        end else begin
          w_reject = 1'b1;
        end
      end
      default: begin
        // NOP and reserved codes: no change, no error
      end
    endcase
    err_d    = w_reject;
    sticky_d = sticky_q | w_reject;
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      count_q  <= count_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign TDP       = w_tdp;
  assign PDP       = w_pdp;
  assign Count     = count_q;
  assign Empty     = (w_cnt == 0);
  assign Full      = (w_cnt == DEPTH);
  assign Err       = err_q;
  assign ErrSticky = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_pilha_parametrizada.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pilha_parametrizada
//  Purpose  : Self-checking bench for pilha_parametrizada. Two instances
//             (8x8 and 16x4) share clock, reset and op; each is compared
//             against a queue-based LIFO reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pilha_parametrizada;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [2:0]  Op = 3'b000;
  logic [7:0]  Da = '0;
  logic [15:0] Db = '0;

  logic [7:0]  tdpA, pdpA;
  logic [3:0]  cntA;
  logic        emptyA, fullA, errA, stA;
  logic [15:0] tdpB, pdpB;
  logic [2:0]  cntB;
  logic        emptyB, fullB, errB, stB;

  int checks = 0;
  int failures = 0;

  // Reference state: back of queue is top of stack
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  bit          ea = 0, sa = 0, eb = 0, sb = 0;

  always #5 Clk = ~Clk;

  pilha_parametrizada #(.WIDTH(8), .DEPTH(8)) dutA (
    .Clk(Clk), .Reset(Reset), .D(Da), .Op(Op),
    .TDP(tdpA), .PDP(pdpA), .Count(cntA), .Empty(emptyA), .Full(fullA),
    .Err(errA), .ErrSticky(stA)
  );

  pilha_parametrizada #(.WIDTH(16), .DEPTH(4)) dutB (
    .Clk(Clk), .Reset(Reset), .D(Db), .Op(Op),
    .TDP(tdpB), .PDP(pdpB), .Count(cntB), .Empty(emptyB), .Full(fullB),
    .Err(errB), .ErrSticky(stB)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // LIFO rules applied to a queue; rejected ops leave the queue alone
  task automatic model_step(ref logic [15:0] q[$], ref bit e, ref bit s,
                            input int depth, input logic [2:0] op, input logic [15:0] d);
    logic [15:0] a, b;
    e = 0;
    case (op)
      3'd1: if (q.size() < depth) q.push_back(d); else e = 1;
      3'd2: if (q.size() >= 1) void'(q.pop_back()); else e = 1;
      3'd3: if (q.size() >= 2) begin
              void'(q.pop_back()); void'(q.pop_back()); q.push_back(d);
            end else e = 1;
      3'd4: if (q.size() >= 2) begin
              a = q.pop_back(); b = q.pop_back(); q.push_back(a); q.push_back(b);
            end else e = 1;
      3'd5: if (q.size() >= 1 && q.size() < depth) q.push_back(q[q.size()-1]); else e = 1;
      default: ;
    endcase
    if (e) s = 1;
  endtask

  function automatic logic [15:0] mtop(input logic [15:0] q[$]);
    return (q.size() > 0) ? q[q.size()-1] : 16'h0;
  endfunction

  function automatic logic [15:0] mpdp(input logic [15:0] q[$]);
    return (q.size() > 1) ? q[q.size()-2] : 16'h0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".A.tdp"},   32'(tdpA),   32'(mtop(qa)));
    chk({tag, ".A.pdp"},   32'(pdpA),   32'(mpdp(qa)));
    chk({tag, ".A.count"}, 32'(cntA),   32'(qa.size()));
    chk({tag, ".A.empty"}, 32'(emptyA), 32'(qa.size() == 0));
    chk({tag, ".A.full"},  32'(fullA),  32'(qa.size() == 8));
    chk({tag, ".A.err"},   32'(errA),   32'(ea));
    chk({tag, ".A.stk"},   32'(stA),    32'(sa));
    chk({tag, ".B.tdp"},   32'(tdpB),   32'(mtop(qb)));
    chk({tag, ".B.pdp"},   32'(pdpB),   32'(mpdp(qb)));
    chk({tag, ".B.count"}, 32'(cntB),   32'(qb.size()));
    chk({tag, ".B.empty"}, 32'(emptyB), 32'(qb.size() == 0));
    chk({tag, ".B.full"},  32'(fullB),  32'(qb.size() == 4));
    chk({tag, ".B.err"},   32'(errB),   32'(eb));
    chk({tag, ".B.stk"},   32'(stB),    32'(sb));
  endtask

  task automatic do_op(input logic [2:0] op, input logic [15:0] d, input string tag);
    @(negedge Clk);
    Op = op;
    Da = d[7:0];
    Db = d;
    @(posedge Clk);
    #1;
    model_step(qa, ea, sa, 8, op, {8'h00, d[7:0]});
    model_step(qb, eb, sb, 4, op, d);
    check_all(tag);
  endtask

  task automatic clear_model();
    qa.delete(); qb.delete();
    ea = 0; sa = 0; eb = 0; sb = 0;
  endtask

  task automatic sync_reset_release();
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    // Reset state
    clear_model();
    #12;
    check_all("rst");
    sync_reset_release();

    // Push three values, then swap and replace-two
    do_op(3'd1, 16'h0011, "push11");
    do_op(3'd1, 16'h0022, "push22");
    do_op(3'd1, 16'h0033, "push33");
    chk("push3.A.tdp_const", 32'(tdpA), 32'h33);
    chk("push3.A.pdp_const", 32'(pdpA), 32'h22);
    do_op(3'd4, 16'h0000, "swap");
    chk("swap.A.tdp_const", 32'(tdpA), 32'h22);
    do_op(3'd3, 16'h005A, "repl2");
    chk("repl2.A.tdp_const", 32'(tdpA), 32'h5A);
    chk("repl2.A.pdp_const", 32'(pdpA), 32'h11);
    chk("repl2.A.cnt_const", 32'(cntA), 32'd2);

    // Fill to full, then rejected push and dup
    for (int i = 3; i <= 8; i++) do_op(3'd1, 16'(i), "fill");
    do_op(3'd2, 16'h0, "pop_top");
    do_op(3'd2, 16'h0, "pop_top2");
    do_op(3'd1, 16'h0007, "push07");
    do_op(3'd1, 16'h0008, "push08");
    chk("full.A.full_const", 32'(fullA), 32'd1);
    do_op(3'd1, 16'h00FF, "push_full");
    chk("push_full.A.err_const", 32'(errA), 32'd1);
    chk("push_full.A.tdp_const", 32'(tdpA), 32'h08);
    do_op(3'd5, 16'h0, "dup_full");
    do_op(3'd0, 16'h0, "nop_after_err");
    chk("nop.A.err_clear", 32'(errA), 32'd0);

    // Drain to empty, watching for stale values
    for (int i = 0; i < 9; i++) do_op(3'd2, 16'h0, "drain");
    do_op(3'd7, 16'h1234, "op111");
    do_op(3'd6, 16'h4321, "op110");

    // Underflow-side boundaries from reset
    Reset = 1'b0;
    #1;
    clear_model();
    sync_reset_release();
    do_op(3'd2, 16'h0, "pop_empty");
    do_op(3'd1, 16'h007E, "push7E");
    do_op(3'd3, 16'h0055, "repl2_one");
    chk("repl2_one.A.tdp_const", 32'(tdpA), 32'h7E);
    do_op(3'd4, 16'h0, "swap_one");
    do_op(3'd5, 16'h0, "dup_one");
    chk("dup_one.A.pdp_const", 32'(pdpA), 32'h7E);

    // Randomised traffic, weighted toward push/pop to reach both bounds
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [2:0] op;
      r = $urandom_range(0, 11);
      case (r)
        0, 1, 2:  op = 3'd1;
        3, 4, 5:  op = 3'd2;
        6, 7:     op = 3'd3;
        8:        op = 3'd4;
        9:        op = 3'd5;
        default:  op = 3'($urandom_range(0, 7));
      endcase
      do_op(op, 16'($urandom), "rand");
    end

    // Asynchronous reset between edges with a loaded, errored stack
    Reset = 1'b0;
    #1;
    clear_model();
    sync_reset_release();
    do_op(3'd2, 16'h0, "pre_pop_err");
    for (int i = 0; i < 5; i++) do_op(3'd1, 16'h00A0 + 16'(i), "pre_fill");
    do_op(3'd0, 16'h0, "pre_nop");
    chk("pre.A.cnt_const", 32'(cntA), 32'd5);
    #2;
    Reset = 1'b0;
    #1;
    clear_model();
    check_all("async_rst");
    sync_reset_release();
    do_op(3'd1, 16'hBEEF, "post_rst_push");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
